// File: rtl/freelist.sv
// Physical-register free list: circular tag buffer with 4-wide compacting pop and push.
// Define FREELIST_ERR_EN to add the sticky o_err misuse flag.
module freelist #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned NARCH = 32,
  parameter int unsigned DEPTH = (1 << WIDTH) - NARCH,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [3:0]         i_allocEn,
  output logic [4*WIDTH-1:0] o_addr4x,
  output logic               o_ready,
  input  logic [3:0]         i_freeEn,
  input  logic [4*WIDTH-1:0] i_freeAddr4x,
  output logic [CW-1:0]      o_count
`ifdef FREELIST_ERR_EN
  ,
  output logic               o_err
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;

  int unsigned   nalloc, ngrant, nfree, kept;
  logic [3:0]    valid, wr_en;
  logic [PW-1:0] wr_idx [4];

  // Pointer advance modulo DEPTH; off never exceeds 4.
  function automatic logic [PW-1:0] wrap_add(logic [PW-1:0] ptr, int unsigned off);
    int unsigned sum;
    sum = 32'(ptr) + off;
    if (sum >= DEPTH) sum = sum - DEPTH;
    return PW'(sum);
  endfunction

  assign o_count = count_q;
  assign o_ready = (count_q >= CW'(4));

  // Each requesting lane takes the next entry after those claimed by lower lanes.
  always_comb begin
    o_addr4x = '0;
    nalloc   = 0;
    for (int k = 0; k < 4; k++) begin
      o_addr4x[k*WIDTH +: WIDTH] = mem[wrap_add(head_q, nalloc)];
      nalloc = nalloc + 32'(i_allocEn[k]);
    end
  end

  // Valid frees pack from tail; once the list would exceed DEPTH the higher lanes drop.
  always_comb begin
    ngrant = o_ready ? nalloc : 0;
    kept   = 32'(count_q) - ngrant;
    nfree  = 0;
    valid  = '0;
    wr_en  = '0;
    for (int k = 0; k < 4; k++) begin
      wr_idx[k] = wrap_add(tail_q, nfree);
      valid[k]  = i_freeEn[k] && (i_freeAddr4x[k*WIDTH +: WIDTH] != '0);
      if (valid[k] && (kept + nfree < DEPTH)) begin
        wr_en[k] = 1'b1;
        nfree    = nfree + 1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[PW'(i)] <= WIDTH'(NARCH + i);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CW'(DEPTH);
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (wr_en[k]) mem[wr_idx[k]] <= i_freeAddr4x[k*WIDTH +: WIDTH];
      end
      head_q  <= wrap_add(head_q, ngrant);
      tail_q  <= wrap_add(tail_q, nfree);
      count_q <= CW'(kept + nfree);
    end
  end

`ifdef FREELIST_ERR_EN
  // Sticky: starved alloc, overflow drop, or free of tag 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err <= 1'b0;
    end else if ((!o_ready && (i_allocEn != '0)) || ((valid & ~wr_en) != '0) ||
                 ((i_freeEn & ~valid) != '0)) begin
      o_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_freelist.sv
// Self-checking bench for freelist: queue-based reference model compared every cycle,
// plus directed literal checks from the test plan.
module tb_freelist;
  localparam int W = 7;
  localparam int D = 96;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   aen = '0;
  logic [3:0]   fen = '0;
  logic [4*W-1:0] faddr = '0;
  logic [4*W-1:0] addr;
  logic         ready;
  logic [6:0]   count;
`ifdef FREELIST_ERR_EN
  logic         err;
`endif

  int nvec = 0;
  int nmis = 0;
  int fl[$];
  bit mvalid = 1'b0;
  bit merr = 1'b0;

  freelist dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_allocEn   (aen),
    .o_addr4x    (addr),
    .o_ready     (ready),
    .i_freeEn    (fen),
    .i_freeAddr4x(faddr),
    .o_count     (count)
`ifdef FREELIST_ERR_EN
    ,
    .o_err       (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lane(input int k);
    return int'(addr[k*W +: W]);
  endfunction

  // Reference model: the free list as an ordered queue of tags.
  always @(negedge clk) begin
    int j;
    int t;
    if (rst) begin
      fl.delete();
      for (int i = 0; i < D; i++) fl.push_back(32 + i);
      merr   = 1'b0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      check("m_count", int'(count), fl.size());
      check("m_ready", int'(ready), int'(fl.size() >= 4));
      if (fl.size() >= 4) begin
        j = 0;
        for (int k = 0; k < 4; k++) begin
          if (aen[k]) begin
            check($sformatf("m_lane%0d", k), lane(k), fl[j]);
            j++;
          end
        end
      end
`ifdef FREELIST_ERR_EN
      check("m_err", int'(err), int'(merr));
`endif
      if (fl.size() >= 4) begin
        for (int k = 0; k < 4; k++) if (aen[k]) void'(fl.pop_front());
      end else if (aen != 0) begin
        merr = 1'b1;
      end
      for (int k = 0; k < 4; k++) begin
        if (fen[k]) begin
          t = int'(faddr[k*W +: W]);
          if (t == 0) merr = 1'b1;
          else if (fl.size() < D) fl.push_back(t);
          else merr = 1'b1;
        end
      end
    end
  end

  task automatic drive(input bit r, input logic [3:0] a, input logic [3:0] f,
                       input int t0, input int t1, input int t2, input int t3);
    rst   = r;
    aen   = a;
    fen   = f;
    faddr = {7'(t3), 7'(t2), 7'(t1), 7'(t0)};
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 4'h0, 4'h0, 0, 0, 0, 0);
    tick(); tick();

    // Reset contents and first full allocation
    drive(0, 4'hf, 4'h0, 0, 0, 0, 0);
    check("rst_count", int'(count), 96);
    check("rst_ready", int'(ready), 1);
    for (int k = 0; k < 4; k++) check("rst_lane", lane(k), 32 + k);
    tick();
    check("a4_count", int'(count), 92);
    for (int k = 0; k < 4; k++) check("a4_lane", lane(k), 36 + k);

    // Sparse request after reset
    drive(1, 4'h0, 4'h0, 0, 0, 0, 0);
    tick();
    drive(0, 4'b1010, 4'h0, 0, 0, 0, 0);
    check("sp_lane1", lane(1), 32);
    check("sp_lane3", lane(3), 33);
    tick();
    drive(0, 4'hf, 4'h0, 0, 0, 0, 0);
    check("sp_count", int'(count), 94);
    check("sp_lane0", lane(0), 34);

    // Drain to the ready threshold and past it
    repeat (22) tick();
    drive(0, 4'b0011, 4'h0, 0, 0, 0, 0);
    tick();
    check("drain_count", int'(count), 4);
    check("drain_ready", int'(ready), 1);
    drive(0, 4'b0001, 4'h0, 0, 0, 0, 0);
    tick();
    check("low_count", int'(count), 3);
    check("low_ready", int'(ready), 0);
    drive(0, 4'hf, 4'h0, 0, 0, 0, 0);
    tick();
    check("starve_count", int'(count), 3);
`ifdef FREELIST_ERR_EN
    check("starve_err", int'(err), 1);
`endif

    // Refill with sparse frees, then allocate across old and new tags
    drive(0, 4'h0, 4'b0101, 40, 0, 41, 0);
    tick();
    check("refill_count", int'(count), 5);
    check("refill_ready", int'(ready), 1);
    drive(0, 4'hf, 4'h0, 0, 0, 0, 0);
    check("refill_lane0", lane(0), 125);
    check("refill_lane1", lane(1), 126);
    check("refill_lane2", lane(2), 127);
    check("refill_lane3", lane(3), 40);
    tick();
    check("refill_after", int'(count), 1);

    // Full list: overflow and tag-0 drops, then balanced alloc/free
    drive(1, 4'h0, 4'h0, 0, 0, 0, 0);
    tick();
    drive(0, 4'h0, 4'b0011, 5, 0, 0, 0);
    tick();
    check("full_count", int'(count), 96);
`ifdef FREELIST_ERR_EN
    check("full_err", int'(err), 1);
`endif
    drive(0, 4'hf, 4'hf, 8, 9, 10, 11);
    tick();
    check("bal_count", int'(count), 96);
    drive(0, 4'hf, 4'h0, 0, 0, 0, 0);
    repeat (23) tick();
    check("tail_count", int'(count), 4);
    for (int k = 0; k < 4; k++) check("tail_lane", lane(k), 8 + k);
    tick();
    check("empty_count", int'(count), 0);
    check("empty_ready", int'(ready), 0);

    // Mixed traffic so both pointers wrap repeatedly; the model checks each cycle
    for (int i = 0; i < 120; i++) begin
      drive(0, 4'((i * 5) % 16), 4'((i * 11 + 7) % 16), (i * 29) % 128,
            (i * 29 + 3) % 128, (i * 29 + 6) % 128, (i * 29 + 9) % 128);
      tick();
    end

    // Reset dominates concurrent alloc and free
    drive(1, 4'hf, 4'hf, 1, 2, 3, 4);
    tick();
    drive(0, 4'hf, 4'h0, 0, 0, 0, 0);
    check("mrst_count", int'(count), 96);
    check("mrst_ready", int'(ready), 1);
    for (int k = 0; k < 4; k++) check("mrst_lane", lane(k), 32 + k);
`ifdef FREELIST_ERR_EN
    check("mrst_err", int'(err), 0);
`endif
    tick();
    drive(0, 4'h0, 4'h0, 0, 0, 0, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
